// File: rtl/osd_trace_arbiter.sv
// Packet-granular round-robin arbiter merging N DII flit streams onto one port.
// Define OSD_TRACE_ARB_OUTREG_EN to drive out_flit from a 2-entry skid buffer.

package osd_dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module osd_trace_arbiter #(
  parameter int N = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  osd_dii_pkg::dii_flit [N-1:0] in_flit,
  output logic [N-1:0]                 in_ready,
  output osd_dii_pkg::dii_flit         out_flit,
  input  logic                         out_ready,
  input  logic [N-1:0]                 req_mask,
  output logic [N-1:0]                 grant,
  output logic                         busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         grant_q, grant_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        win_idx;
  logic                 win_found;
  int                   scan_idx;
  osd_dii_pkg::dii_flit owner_flit;
  logic                 owner_take;
  logic                 pkt_done;

  assign owner_flit = in_flit[owner_q];
  assign pkt_done   = owner_take && owner_flit.last;
  assign grant      = grant_q;
  assign busy       = (state_q == LOCKED);

  // First masked requester found scanning upward from the last owner + 1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 1; k <= N; k++) begin
      scan_idx = (int'(ptr_q) + k) % N;
      if (!win_found && in_flit[IW'(scan_idx)].valid && req_mask[IW'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          owner_d = win_idx;
          grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
        end
      end
      LOCKED: begin
        if (pkt_done) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef OSD_TRACE_ARB_OUTREG_EN
  osd_dii_pkg::dii_flit buf_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;
  logic                 buf_full, push, pop;

  // Packet end is taken on the write side so the grant frees while the buffer drains.
  assign buf_full   = (count_q == 2'd2);
  assign push       = (state_q == LOCKED) && owner_flit.valid && !buf_full;
  assign pop        = (count_q != 2'd0) && out_ready;
  assign owner_take = push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= owner_flit;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    in_ready = '0;
    out_flit = '0;
    if (state_q == LOCKED) begin
      in_ready[owner_q] = !buf_full;
    end
    if (count_q != 2'd0) begin
      out_flit = buf_q[rd_ptr_q];
    end
  end
`else
  assign owner_take = (state_q == LOCKED) && owner_flit.valid && out_ready;

  always_comb begin
    in_ready = '0;
    out_flit = '0;
    if (state_q == LOCKED) begin
      in_ready[owner_q] = out_ready;
      out_flit          = owner_flit;
    end
  end
`endif

endmodule

// File: tb/tb_osd_trace_arbiter.sv
// Directed scoreboard bench for osd_trace_arbiter (N=4): ordering, round-robin,
// masking, owner stalls, downstream backpressure and mid-packet reset.

module tb_osd_trace_arbiter;
  import osd_dii_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  dii_flit [N-1:0]  in_flit;
  logic [N-1:0]     in_ready;
  dii_flit          out_flit;
  logic             out_ready;
  logic [N-1:0]     req_mask;
  logic [N-1:0]     grant;
  logic             busy;

  int               checks = 0;
  int               errors = 0;
  logic [16:0]      src_mem [N][32];
  int               src_head [N];
  int               src_tail [N];
  logic             hold [N];
  int               accepted [N];
  logic [16:0]      exp_q [$];
  int               grant_log [$];
  logic [N-1:0]     prev_grant;
  int               out_count;
  int               cur_src;
  logic             ready0_seen;

  osd_trace_arbiter #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flit  (in_flit),
    .in_ready (in_ready),
    .out_flit (out_flit),
    .out_ready(out_ready),
    .req_mask (req_mask),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_head[i] < src_tail[i] && !hold[i]) begin
        in_flit[i].valid = 1'b1;
        in_flit[i].last  = src_mem[i][src_head[i]][16];
        in_flit[i].data  = src_mem[i][src_head[i]][15:0];
      end else begin
        in_flit[i] = '0;
      end
    end
  endtask

  task automatic load_word(input int src, input logic last, input logic [15:0] data);
    src_mem[src][src_tail[src]] = {last, data};
    src_tail[src]++;
  endtask

  // Upper nibble of data carries the source so interleaving is visible downstream.
  task automatic load_packet(input int src, input int len, input int pkt);
    for (int f = 0; f < len; f++) begin
      load_word(src, (f == len - 1), {4'(src), 4'(pkt), 8'(f + 1)});
    end
  endtask

  function automatic int log_at(input int k);
    if (k < grant_log.size()) return grant_log[k];
    return -1;
  endfunction

  function automatic logic all_done();
    logic d;
    d = !busy && (exp_q.size() == 0) && !out_flit.valid;
    for (int i = 0; i < N; i++) begin
      if (src_head[i] < src_tail[i]) d = 1'b0;
    end
    return d;
  endfunction

  task automatic check_flit();
    logic [16:0] exp_flit;
    out_count++;
    check_output("sb_pending", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      exp_flit = exp_q.pop_front();
      check_output("flit", 32'({out_flit.last, out_flit.data}), 32'(exp_flit));
    end
    if (cur_src >= 0) begin
      check_output("no_interleave", 32'(out_flit.data[15:12]), 32'(cur_src));
    end
    cur_src = out_flit.last ? -1 : int'(out_flit.data[15:12]);
  endtask

  // One clock: sample handshakes at the falling edge, update drivers after the rising edge.
  task automatic apply_stimulus();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (in_flit[i].valid && in_ready[i]) begin
        exp_q.push_back({in_flit[i].last, in_flit[i].data});
        src_head[i]++;
        accepted[i]++;
      end
    end
    if (in_ready[0]) ready0_seen = 1'b1;
    if (out_flit.valid && out_ready) check_flit();
    if (grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) grant_log.push_back(i);
      end
    end
    prev_grant = grant;
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!all_done() && n < budget) begin
      apply_stimulus();
      n++;
    end
    check_output(tag, 32'(all_done()), 32'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
      hold[i]     = 1'b0;
      accepted[i] = 0;
    end
    exp_q.delete();
    grant_log.delete();
    prev_grant  = '0;
    out_count   = 0;
    cur_src     = -1;
    ready0_seen = 1'b0;
    out_ready   = 1'b1;
    req_mask    = '1;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_grant", 32'(grant), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_out_flit", 32'(out_flit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;

    // Single 3-flit packet on input 0.
    apply_reset();
    load_word(0, 1'b0, 16'h0011);
    load_word(0, 1'b0, 16'h0022);
    load_word(0, 1'b1, 16'h0033);
    drive_inputs();
    apply_stimulus();
    check_output("t1_grant", 32'(grant), 32'h1);
    check_output("t1_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 20) begin
      apply_stimulus();
      n++;
    end
    check_output("t1_locked_cycles", 32'(n), 32'd3);
    wait_done(20, "t1_done");
    check_output("t1_out_count", 32'(out_count), 32'd3);

    // All four inputs stream 2-flit packets.
    apply_reset();
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 3; p++) load_packet(i, 2, p);
    end
    drive_inputs();
    wait_done(300, "t2_done");
    check_output("t2_grant_count", 32'(grant_log.size()), 32'd12);
    for (int k = 0; k < 12; k++) begin
      check_output("t2_rr_order", 32'(log_at(k)), 32'(k % N));
    end

    // Only input 1 is eligible while both request.
    apply_reset();
    req_mask = 4'b0010;
    load_packet(0, 2, 0);
    load_packet(1, 2, 0);
    drive_inputs();
    n = 0;
    while (!((src_head[1] == src_tail[1]) && !busy && exp_q.size() == 0) && n < 60) begin
      apply_stimulus();
      n++;
    end
    check_output("t3_timeout", 32'(n < 60), 32'd1);
    check_output("t3_ready0", 32'(ready0_seen), 32'd0);
    check_output("t3_first_grant", 32'(log_at(0)), 32'd1);
    check_output("t3_src0_left", 32'(src_tail[0] - src_head[0]), 32'd2);
    req_mask = '1;
    wait_done(60, "t3_done");
    check_output("t3_second_grant", 32'(log_at(1)), 32'd0);
    check_output("t3_src0_served", 32'(accepted[0]), 32'd2);

    // Owner stalls mid-packet while input 1 waits.
    apply_reset();
    load_packet(0, 4, 1);
    load_packet(1, 2, 1);
    drive_inputs();
    n = 0;
    while (accepted[0] < 2 && n < 20) begin
      apply_stimulus();
      n++;
    end
    check_output("t4_timeout", 32'(accepted[0]), 32'd2);
    hold[0] = 1'b1;
    drive_inputs();
    for (int c = 0; c < 5; c++) begin
      apply_stimulus();
      check_output("t4_hold_grant", 32'(grant), 32'h1);
      check_output("t4_hold_valid", 32'(out_flit.valid), 32'd0);
    end
    hold[0] = 1'b0;
    drive_inputs();
    wait_done(60, "t4_done");
    check_output("t4_grant0", 32'(log_at(0)), 32'd0);
    check_output("t4_grant1", 32'(log_at(1)), 32'd1);
    check_output("t4_src1_served", 32'(accepted[1]), 32'd2);

    // Downstream ready toggles during a 4-flit packet.
    apply_reset();
    load_packet(2, 4, 2);
    drive_inputs();
    n = 0;
    while (!all_done() && n < 60) begin
      apply_stimulus();
      out_ready = ~out_ready;
      n++;
    end
    check_output("t5_done", 32'(all_done()), 32'd1);
    check_output("t5_out_count", 32'(out_count), 32'd4);
    check_output("t5_accepted", 32'(accepted[2]), 32'd4);
    out_ready = 1'b1;

    // Reset in the middle of a packet.
    apply_reset();
    load_packet(0, 4, 3);
    drive_inputs();
    n = 0;
    while (accepted[0] < 2 && n < 20) begin
      apply_stimulus();
      n++;
    end
    check_output("t6_timeout", 32'(accepted[0]), 32'd2);
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_grant", 32'(grant), 32'd0);
    check_output("t6_rst_valid", 32'(out_flit.valid), 32'd0);
    check_output("t6_rst_busy", 32'(busy), 32'd0);
    apply_reset();
    load_packet(1, 2, 4);
    load_packet(0, 2, 4);
    drive_inputs();
    apply_stimulus();
    check_output("t6_restart_grant", 32'(grant), 32'h1);
    wait_done(60, "t6_done");
    check_output("t6_grant0", 32'(log_at(0)), 32'd0);
    check_output("t6_grant1", 32'(log_at(1)), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_trace_arbiter.md
# osd_trace_arbiter

Packet-granular round-robin arbiter that shares one DII debug output port between N trace/event packetizers, such as several core trace modules in one debug cluster. It grants one requester at a time and holds the grant until that requester's `last` flit has been transferred, so packets are never interleaved. It sits between the packetizer outputs and the regaccess layer / debug ring interface of a multi-source trace module.

## Interface
Parameters:
- `N`, default 2: number of requesting DII flit streams, 2..8.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_flit`  in  N × dii_flit  requester flit streams (`valid`, `last`, `data[15:0]` each).
- `in_ready`  out  N  per-requester ready.
- `out_flit`  out  dii_flit  merged stream.
- `out_ready`  in  1  downstream ready.
- `req_mask`  in  N  1 = requester may be granted; 0 = requester is excluded from arbitration.
- `grant`  out  N  one-hot current owner; all-zero when idle.
- `busy`  out  1  1 while in LOCKED.

## Operation
- Transfer on any DII link occurs when `valid & ready` are both 1 in the same cycle.
- State IDLE:
  - Candidates are `in_flit[i].valid & req_mask[i]`.
  - The winner is the first candidate found searching upward from `ptr+1`, modulo N.
  - If a winner exists, register `grant`=onehot(winner) and go to LOCKED.
  - No flit is transferred in IDLE.
- State LOCKED with owner g:
  - `out_flit` = `in_flit[g]`.
  - `in_ready[g]` = downstream ready; all other `in_ready` are 0.
  - On a transfer with `last`=1: set `ptr`=g, clear `grant`, return to IDLE.
- `req_mask` is sampled only in IDLE. Deasserting `req_mask[g]` during LOCKED does not abort the packet.
- If the owner deasserts `valid` mid-packet, the arbiter stays LOCKED with `out_flit.valid`=0. There is no timeout.
- Packets of any length are accepted. A single-flit packet (`last` on first flit) is legal.
- `busy` = (state == LOCKED).

## Timing
- Reset (async assert, sync deassert handled externally):
  - state=IDLE, `ptr`=N-1 (so input 0 wins first).
  - `grant`=0, `busy`=0, `in_ready`=0.
  - `out_flit.valid`=0, `out_flit.last`=0, `out_flit.data`=0.
- Arbitration latency: 1 cycle from a valid request in IDLE to grant, plus the configured output latency before the first flit appears.
- A packet end in cycle t puts the arbiter in IDLE at t+1. The next grant is registered at the end of t+1, and the next packet's first flit can transfer at t+2.
- Minimum occupancy per packet is one idle cycle plus L flit cycles.
- With simultaneous requests from all N inputs, each is granted exactly once per N packets.
- Asserting reset mid-packet drops the packet and returns the arbiter to IDLE immediately.

## Configuration
- `OSD_TRACE_ARB_OUTREG_EN` defined:
  - `out_flit` is driven from a 2-entry skid buffer.
  - `in_ready[g]` = buffer not full. Full throughput is kept.
  - Flit latency is +1 cycle. No combinational path from `out_ready` to `in_ready`.
  - `last` is detected on the buffer write side. The buffer drains independently after the grant is released.
  - Reset empties the buffer.
- Undefined:
  - `out_flit`/`in_ready[g]` are purely combinational pass-through of the owner and `out_ready`.
  - Zero added latency.

## Test plan
- Reset release, `in_flit[0]` 3-flit packet 0x0011/0x0022/0x0033, `out_ready`=1 → grant=0b01 one cycle later; flits appear in order on consecutive cycles, last on 0x0033; busy drops the following cycle.
- N=4, all inputs continuously send 2-flit packets, `req_mask`=0xF → grant sequence 0,1,2,3,0,1…; no flit interleaving between packets.
- `req_mask`=0b10 while both inputs valid → only input 1 granted; input 0 `in_ready` stays 0.
- Owner drops `valid` for 5 cycles mid-packet while input 1 requests → grant held, `out_flit.valid`=0 for those cycles, input 1 served only after owner's last flit.
- `out_ready` toggled 1,0,1,0 during a 4-flit packet → every flit transferred exactly once, none duplicated or lost (both config variants).
- `rst_n` asserted mid-packet → in the same cycle grant=0, `out_flit.valid`=0; after release, arbitration restarts with input 0 priority.
